// File: rtl/nport_bus_arbiter_pkg.sv
// Shared types and the winner-selection helper for the N-port Sysbus arbiter.
package nport_bus_arbiter_pkg;

    localparam int unsigned MAX_PORTS  = 8;
    localparam int unsigned PTR_W      = 3;
    localparam int unsigned TAG_WR_BIT = 12;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    // First requesting port at or after ptr, searching upward with wrap at nports.
    function automatic int unsigned pick_winner(input logic [MAX_PORTS-1:0] req,
                                                input logic [PTR_W-1:0]     ptr,
                                                input int unsigned          nports);
        int unsigned win;
        int unsigned idx;
        logic        found;
        win   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            idx = (32'(ptr) + i) % nports;
            if (!found && (i < nports) && req[idx[PTR_W-1:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/nport_bus_arbiter_arb_pick.sv
// Combinational picker: returns the winning port index for a request vector and start pointer.
module arb_pick
    import nport_bus_arbiter_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned IDX_W  = 1
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  winner,
    output logic              any_req
);

    logic [MAX_PORTS-1:0] req_ext;
    logic [PTR_W-1:0]     ptr_ext;

    always_comb begin
        req_ext             = '0;
        req_ext[NPORTS-1:0] = req;
        ptr_ext             = PTR_W'(ptr);
    end

    assign winner  = IDX_W'(pick_winner(req_ext, ptr_ext, NPORTS));
    assign any_req = |req;

endmodule

// File: rtl/nport_bus_arbiter.sv
// N-requester Sysbus arbiter owning one whole transaction (request, write data, read response).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest port index wins.
module nport_bus_arbiter
    import nport_bus_arbiter_pkg::*;
#(
    parameter int unsigned NPORTS     = 2,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 13,
    parameter int unsigned WR_BEATS   = 8,
    parameter int unsigned RESP_BEATS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NPORTS-1:0]             p_reqcyc,
    input  logic [NPORTS*DATA_WIDTH-1:0]  p_req,
    input  logic [NPORTS*TAG_WIDTH-1:0]   p_reqtag,
    output logic [NPORTS-1:0]             p_reqack,
    output logic [NPORTS-1:0]             p_respcyc,
    output logic [NPORTS*DATA_WIDTH-1:0]  p_resp,
    output logic [NPORTS*TAG_WIDTH-1:0]   p_resptag,
    input  logic [NPORTS-1:0]             p_respack,
    output logic                          bus_reqcyc,
    output logic [DATA_WIDTH-1:0]         bus_req,
    output logic [TAG_WIDTH-1:0]          bus_reqtag,
    input  logic                          bus_reqack,
    input  logic                          bus_respcyc,
    input  logic [DATA_WIDTH-1:0]         bus_resp,
    input  logic [TAG_WIDTH-1:0]          bus_resptag,
    output logic                          bus_respack,
    output logic [NPORTS-1:0]             grant,
    output logic                          busy
);

    localparam int unsigned IDX_W     = $clog2(NPORTS);
    localparam int unsigned MAX_BEATS = (WR_BEATS > RESP_BEATS) ? WR_BEATS : RESP_BEATS;
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] WrLast   = CNT_W'(WR_BEATS);
    localparam logic [CNT_W-1:0] RespLast = CNT_W'(RESP_BEATS - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr, winner;
    logic             any_req;

    logic                  own_reqcyc;
    logic [DATA_WIDTH-1:0] own_req;
    logic [TAG_WIDTH-1:0]  own_reqtag;
    logic                  req_beat, resp_beat;

    assign own_reqcyc = p_reqcyc[owner_q];
    assign own_req    = p_req[owner_q*DATA_WIDTH +: DATA_WIDTH];
    assign own_reqtag = p_reqtag[owner_q*TAG_WIDTH +: TAG_WIDTH];
    assign req_beat   = (state_q == StReq) && own_reqcyc && bus_reqack;
    assign resp_beat  = (state_q == StResp) && bus_respcyc && p_respack[owner_q];

    arb_pick #(
        .NPORTS (NPORTS),
        .IDX_W  (IDX_W)
    ) u_arb_pick (
        .req     (p_reqcyc),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StIdle && any_req) begin
            ptr_d = (winner == IDX_W'(NPORTS - 1)) ? '0 : winner + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // In REQ a nonzero count can only mean a write data phase: reads leave on their first beat.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d = winner;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (cnt_q == '0 && !own_reqcyc) begin
                    state_d = StIdle;
                end else if (req_beat) begin
                    if (cnt_q == '0 && !own_reqtag[TAG_WIDTH-1]) begin
                        cnt_d   = '0;
                        state_d = StResp;
                    end else if (cnt_q == WrLast) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StResp: begin
                if (resp_beat) begin
                    if (cnt_q == RespLast) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        p_reqack    = '0;
        p_respcyc   = '0;
        p_resp      = '0;
        p_resptag   = '0;
        grant       = '0;
        busy        = 1'b0;
        unique case (state_q)
            StReq: begin
                busy              = 1'b1;
                grant[owner_q]    = 1'b1;
                bus_reqcyc        = own_reqcyc;
                bus_req           = own_req;
                bus_reqtag        = own_reqtag;
                p_reqack[owner_q] = bus_reqack;
            end
            StResp: begin
                busy                                         = 1'b1;
                grant[owner_q]                               = 1'b1;
                p_respcyc[owner_q]                           = bus_respcyc;
                p_resp[owner_q*DATA_WIDTH +: DATA_WIDTH]     = bus_resp;
                p_resptag[owner_q*TAG_WIDTH +: TAG_WIDTH]    = bus_resptag;
                bus_respack                                  = p_respack[owner_q];
            end
            default: ;
        endcase
    end

endmodule
